// File: rtl/mult_booth_32_if.sv
// Handshake and data bundle between the execute stage and the Booth multiplier.
// The master side starts multiplies; the slave side is the multiplier itself.
interface mult_booth_32_if;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/mult_booth_32.sv
// Multicycle signed 32x32 radix-2 Booth multiplier (one step per clock) with
// its shared ripple-carry adder_32; returns the low word plus a signed-overflow flag.
module adder_32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_ovf
);
  logic [32:0] w_c;

  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int unsigned i = 0; i < 32; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  // Signed overflow: carry into the MSB differs from carry out of it.
  assign o_ovf = w_c[32] ^ w_c[31];
endmodule

module mult_booth_32 (
  input  logic                   clock,
  input  logic                   reset,
  mult_booth_32_if.slave         bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [5:0]  r_count;
  logic [31:0] r_m;
  logic [31:0] r_acc;
  logic [31:0] r_q;
  logic        r_qm1;
  logic [31:0] r_result;
  logic        r_exception;

  logic [1:0]  w_sel;
  logic        w_add_en;
  logic        w_sub;
  logic [31:0] w_adder_b;
  logic [31:0] w_sum;
  logic        w_ovf;
  logic [31:0] w_s;
  logic        w_o;
  logic        w_sgn;
  logic [31:0] w_acc_new;
  logic [31:0] w_q_new;
  logic        w_start;
  logic        w_last;

  assign w_start = bus.ctrl_MULT;
  assign w_last  = (r_count == 6'd31);

  // Booth recoding of the current multiplier bit pair.
  assign w_sel     = {r_q[0], r_qm1};
  assign w_sub     = (w_sel == 2'b10);
  assign w_add_en  = w_sel[1] ^ w_sel[0];
  assign w_adder_b = w_sub ? ~r_m : r_m;

  adder_32 u_adder (
    .i_a   (r_acc),
    .i_b   (w_adder_b),
    .i_cin (w_sub),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  // Sign of the true 33-bit sum keeps the shift correct when M = 0x80000000.
  assign w_s       = w_add_en ? w_sum : r_acc;
  assign w_o       = w_add_en & w_ovf;
  assign w_sgn     = w_s[31] ^ w_o;
  assign w_acc_new = {w_sgn, w_s[31:1]};
  assign w_q_new   = {w_s[0], r_q[31:1]};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_start) begin
      w_state_next = RUN;
    end else begin
      case (r_state)
        IDLE:    w_state_next = IDLE;
        RUN:     w_state_next = w_last ? DONE : RUN;
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count     <= '0;
      r_m         <= '0;
      r_acc       <= '0;
      r_q         <= '0;
      r_qm1       <= 1'b0;
      r_result    <= '0;
      r_exception <= 1'b0;
    end else if (w_start) begin
      r_count <= '0;
      r_m     <= bus.data_operandA;
      r_acc   <= '0;
      r_q     <= bus.data_operandB;
      r_qm1   <= 1'b0;
    end else if (r_state == RUN) begin
      r_acc   <= w_acc_new;
      r_q     <= w_q_new;
      r_qm1   <= r_q[0];
      r_count <= r_count + 6'd1;
      if (w_last) begin
        r_result    <= w_q_new;
        r_exception <= (w_acc_new != {32{w_q_new[31]}});
      end
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exception;
  assign bus.data_resultRDY = (r_state == DONE);
  assign bus.busy           = (r_state == RUN);
endmodule

// File: tb/tb_mult_booth_32.sv
// Directed and randomized checks of mult_booth_32 against a 64-bit signed product model.
module tb_mult_booth_32;
  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [31:0] prev_result;
  logic        prev_exc;

  mult_booth_32_if bus ();

  mult_booth_32 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    p  = sa * sb;
    r  = p[31:0];
    e  = (p != {{32{p[31]}}, p[31:0]});
  endfunction

  // Called at a negedge: start on the next posedge, follow 32 RUN cycles, check DONE.
  task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input bit back2back);
    logic [31:0] er;
    logic        ee;
    model(a, b, er, ee);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clock);
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
      check({tag, "_busy"}, {62'd0, bus.busy, bus.data_resultRDY}, 64'd2);
      check({tag, "_hold"}, {31'd0, bus.data_exception, bus.data_result}, {31'd0, prev_exc, prev_result});
    end
    @(negedge clock);
    check({tag, "_rdy"}, {62'd0, bus.busy, bus.data_resultRDY}, 64'd1);
    check({tag, "_res"}, {32'd0, bus.data_result}, {32'd0, er});
    check({tag, "_exc"}, {63'd0, bus.data_exception}, {63'd0, ee});
    prev_result = er;
    prev_exc    = ee;
    if (!back2back) begin
      @(negedge clock);
      check({tag, "_idle"}, {62'd0, bus.busy, bus.data_resultRDY}, 64'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    prev_result = '0;
    prev_exc    = 1'b0;
    reset = 1'b1;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = 32'hDEADBEEF;
    bus.data_operandB = 32'h12345678;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("reset_out", {bus.busy, bus.data_resultRDY, bus.data_exception, bus.data_result},
          {3'b000, 32'd0});

    run_check("d6x7",      32'd6,          32'd7,          1'b0);
    check("d6x7_val", {32'd0, prev_result}, 64'd42);
    run_check("dm3x5",     32'hFFFFFFFD,   32'd5,          1'b0);
    check("dm3x5_val", {32'd0, prev_result}, 64'hFFFFFFF1);
    run_check("d5xm3",     32'd5,          32'hFFFFFFFD,   1'b0);
    run_check("dminx1",    32'h80000000,   32'd1,          1'b0);
    run_check("dminxm1",   32'h80000000,   32'hFFFFFFFF,   1'b0);
    check("dminxm1_exc", {63'd0, prev_exc}, 64'd1);
    run_check("dminxmin",  32'h80000000,   32'h80000000,   1'b0);
    run_check("d64kx64k",  32'd65536,      32'd65536,      1'b0);
    run_check("dmaxxmax",  32'h7FFFFFFF,   32'h7FFFFFFF,   1'b0);
    run_check("dzero",     32'd0,          32'hFFFFFFFF,   1'b0);

    // Restart mid-run: the second start lands on the 10th RUN edge.
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = 32'd1000;
    bus.data_operandB = 32'd3;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clock);
      check("restart_norde", {62'd0, bus.busy, bus.data_resultRDY}, 64'd2);
    end
    run_check("restart", 32'd7, 32'd8, 1'b0);
    check("restart_val", {32'd0, prev_result}, 64'd56);

    // Back-to-back start issued while in DONE.
    run_check("b2b_a", 32'hFFFF0001, 32'd12345, 1'b1);
    run_check("b2b_b", 32'd99,       32'hFFFFFF00, 1'b0);

    // Reset in the middle of a multiply.
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = 32'd123;
    bus.data_operandB = 32'd456;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset_out", {bus.busy, bus.data_resultRDY, bus.data_exception, bus.data_result},
          {3'b000, 32'd0});
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      check("midreset_nordy", {62'd0, bus.busy, bus.data_resultRDY}, 64'd0);
    end
    prev_result = '0;
    prev_exc    = 1'b0;

    for (int n = 0; n < 24; n++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      if (n % 4 == 1) a = $signed(16'($urandom));
      if (n % 4 == 2) b = $signed(16'($urandom));
      run_check("rand", a, b, (n % 5 == 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_booth_32.md
Name: mult_booth_32

Overview:
- Multicycle signed 32x32 multiplier for the execute stage (radix-2 Booth, one step per clock).
- Sits directly upstream of adder_32: one adder_32 instance forms every partial-product add/subtract. Subtract uses the inverted multiplicand with Cin=1.
- The result (low 32 bits) and an overflow exception feed the writeback/exception logic, with a one-cycle ready pulse.

Parameters:
- None. Datapath width is fixed at 32 by adder_32.

Ports:
- clock  input  1  sole clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; priority over all other inputs
- ctrl_MULT  input  1  start pulse; operands sampled on the same edge
- data_operandA  input  32  multiplicand M, two's complement
- data_operandB  input  32  multiplier Q, two's complement
- data_result  output  32  low 32 bits of the product, registered
- data_exception  output  1  product not representable in signed 32 bits, registered
- data_resultRDY  output  1  one-cycle pulse: result and exception valid
- busy  output  1  high while in RUN

Behaviour:
- States: IDLE, RUN, DONE. Iteration counter is 6 bits.
- Registers: M[31:0], accumulator ACC[31:0], Q[31:0], q_m1 (1 bit).
- Reset edge: state=IDLE, count=0, and all registers cleared. Outputs after reset: data_result=0, data_exception=0, data_resultRDY=0, busy=0.
- Start: an edge with ctrl_MULT=1 and reset=0, in any state, does the following:
  - M<=A, Q<=B, ACC<=0, q_m1<=0, count<=0, state<=RUN.
  - If a multiply is already in progress it is abandoned. No ready pulse is produced for it.
- RUN edge (ctrl_MULT=0), one Booth step:
  - Inspect {Q[0], q_m1}.
    - 01: S = ACC + M (adder B=M, Cin=0).
    - 10: S = ACC - M (adder B=~M, Cin=1).
    - 00/11: no add; S=ACC, O=0.
  - Sign bit for the shift: sgn = S[31] XOR O. This gives the true sign of the 33-bit sum and handles M = 0x80000000.
  - Arithmetic right shift of {sgn, S, Q, q_m1}: ACC <= {sgn, S[31:1]}, Q <= {S[0], Q[31:1]}, q_m1 <= Q[0].
  - count <= count+1.
  - On the edge where count==31 (the 32nd step), also state<=DONE. The post-shift values are used to load the outputs:
    - data_result <= Q_new.
    - data_exception <= (ACC_new != {32{Q_new[31]}}).
- DONE: data_resultRDY=1 for exactly this cycle. The next edge goes to IDLE, or to RUN if ctrl_MULT=1.
- Latency: ready is high during the cycle after the 32nd edge following the start edge. A back-to-back start while in DONE is legal.
- data_result and data_exception hold their values until the next completed multiply or reset. They do not change during RUN.
- busy = (state==RUN). data_resultRDY = (state==DONE).
- Reset mid-operation: the multiply is discarded, outputs go to 0, and no ready pulse is produced.
- Operands are sampled only on the start edge. Input changes during RUN have no effect.
- ctrl_MULT high on consecutive edges restarts on each edge; only the last start completes.

Test Plan:
- A=6, B=7, one-cycle ctrl_MULT -> busy for 32 cycles, then RDY for 1 cycle; result=42, exception=0. RDY stays 0 at every other cycle.
- A=-3 (0xFFFFFFFD), B=5 -> result=0xFFFFFFF1, exception=0. Repeat with A=5, B=-3 -> same.
- A=0x80000000, B=1 -> result=0x80000000, exception=0.
- A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1.
- A=0x80000000, B=0x80000000 -> result=0, exception=1 (exercises the sgn correction).
- A=65536, B=65536 -> result=0, exception=1.
- Restart and reset:
  - Start 1000x3; at the 10th RUN edge start 7x8 -> one RDY only, 32 edges after the second start, with result=56.
  - Separately, assert reset for 1 edge mid-RUN -> result=0, exception=0, no RDY.
